bus_access_seq: RTL and testbench

BUS_ACCESS_SEQ -- requirements
Module: bus_access_seq

---
 rtl/bus_access_seq.sv | 109 ++++++++++
 tb/tb_bus_access_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_access_seq.sv
// Single-master bus access sequencer: IDLE -> SETUP -> STROBE -> HOLD.
// The strobe length is region-dependent and set by addr[7:6].
module bus_access_seq #(
  parameter logic [3:0] WAIT1 = 4'd1,
  parameter logic [3:0] WAIT2 = 4'd1,
  parameter logic [3:0] WAIT3 = 4'd2,
  parameter logic [3:0] WAIT4 = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr_in,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] addr,
  output logic       CS,
  output logic       rd_n,
  output logic       wr_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0] state;
  logic [3:0] count;
  logic       access_wr;

  function automatic logic [3:0] region_wait(input logic [1:0] region);
    case (region)
      2'b00:   region_wait = WAIT1;
      2'b01:   region_wait = WAIT2;
      2'b10:   region_wait = WAIT3;
      2'b11:   region_wait = WAIT4;
      default: region_wait = WAIT1;
    endcase
  endfunction

  assign ready = (state == IDLE);

  // Bus outputs are set on the edge entering each state so they are valid for the whole state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      access_wr <= 1'b0;
      addr      <= 8'h00;
      CS        <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
      rdata     <= 8'h00;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr      <= addr_in;
            access_wr <= wr;
            data_out  <= wdata;
            data_oe   <= wr;
            CS        <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          count <= region_wait(addr[7:6]);
          rd_n  <= access_wr;
          wr_n  <= ~access_wr;
          state <= STROBE;
        end
        STROBE: begin
          if (count == 4'd0) begin
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            done  <= 1'b1;
            if (!access_wr) begin
              rdata <= data_in;
            end
            state <= HOLD;
          end else begin
            count <= count - 4'd1;
          end
        end
        HOLD: begin
          CS      <= 1'b1;
          data_oe <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          CS    <= 1'b1;
          rd_n  <= 1'b1;
          wr_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_access_seq.sv
// Self-checking bench for bus_access_seq: directed scenarios plus random accesses
// on three instances (default waits, WAIT1=0, WAIT1=15) against a cycle-count model.
module tb_bus_access_seq;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] req_v;
  logic wr;
  logic [7:0] addr_in, wdata, data_in;
  logic [2:0] ready_v, done_v, cs_v, rd_n_v, wr_n_v, oe_v;
  logic [2:0][7:0] rdata_v, addr_v, dout_v;

  int errors = 0;
  int checks = 0;

  // Strobe-extension table per instance and region, and last captured read data.
  int wait_tab [3][4] = '{'{1, 1, 2, 3}, '{0, 1, 2, 3}, '{15, 1, 2, 3}};
  logic [7:0] model_rdata [3];

  always #5 clk = ~clk;

  bus_access_seq u0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .wr(wr), .addr_in(addr_in), .wdata(wdata),
    .ready(ready_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .addr(addr_v[0]), .CS(cs_v[0]),
    .rd_n(rd_n_v[0]), .wr_n(wr_n_v[0]), .data_in(data_in), .data_out(dout_v[0]), .data_oe(oe_v[0]));

  bus_access_seq #(.WAIT1(4'd0)) u1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .wr(wr), .addr_in(addr_in), .wdata(wdata),
    .ready(ready_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .addr(addr_v[1]), .CS(cs_v[1]),
    .rd_n(rd_n_v[1]), .wr_n(wr_n_v[1]), .data_in(data_in), .data_out(dout_v[1]), .data_oe(oe_v[1]));

  bus_access_seq #(.WAIT1(4'd15)) u2 (
    .clk(clk), .reset(reset), .req(req_v[2]), .wr(wr), .addr_in(addr_in), .wdata(wdata),
    .ready(ready_v[2]), .done(done_v[2]), .rdata(rdata_v[2]), .addr(addr_v[2]), .CS(cs_v[2]),
    .rd_n(rd_n_v[2]), .wr_n(wr_n_v[2]), .data_in(data_in), .data_out(dout_v[2]), .data_oe(oe_v[2]));

  function automatic int exp_wait(input int idx, input logic [7:0] a);
    logic [1:0] region;
    region = a[7:6];
    return wait_tab[idx][region];
  endfunction

  // Issue one access on instance idx and measure what the bus did until CS returns high.
  task automatic run_access(input int idx, input logic w, input logic [7:0] a, input logic [7:0] wd,
                            input logic [7:0] din, input bit noise,
                            output int cs_low, output int rd_low, output int wr_low,
                            output int first_strobe, output int done_at, output int done_cnt,
                            output int addr_bad, output int oe_bad, output int dout_bad,
                            output int illegal, output logic ready_end, output logic oe_end);
    int wt;
    wt = exp_wait(idx, a);
    cs_low = 0; rd_low = 0; wr_low = 0; first_strobe = -1; done_at = -1; done_cnt = 0;
    addr_bad = 0; oe_bad = 0; dout_bad = 0; illegal = 0; ready_end = 1'b0; oe_end = 1'b1;
    @(negedge clk);
    wr = w; addr_in = a; wdata = wd; data_in = din;
    req_v = 3'b000;
    req_v[idx] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cs_v[idx] === 1'b0) begin
        cs_low++;
        if (addr_v[idx] !== a) addr_bad++;
        if (oe_v[idx] !== w) oe_bad++;
        if (dout_v[idx] !== wd) dout_bad++;
      end
      if (rd_n_v[idx] === 1'b0) begin
        rd_low++;
        if (first_strobe < 0) first_strobe = k;
      end
      if (wr_n_v[idx] === 1'b0) begin
        wr_low++;
        if (first_strobe < 0) first_strobe = k;
      end
      if (rd_n_v[idx] === 1'b0 && wr_n_v[idx] === 1'b0) illegal++;
      if (cs_v[idx] !== 1'b0 && (rd_n_v[idx] === 1'b0 || wr_n_v[idx] === 1'b0)) illegal++;
      if (done_v[idx] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (cs_v[idx] === 1'b1) begin
        ready_end = ready_v[idx];
        oe_end = oe_v[idx];
        break;
      end
      if (noise && k <= wt + 2) begin
        req_v[idx] = 1'($urandom);
        wr = 1'($urandom);
        addr_in = 8'($urandom);
        wdata = 8'($urandom);
      end else begin
        req_v = 3'b000;
      end
    end
    req_v = 3'b000;
    if (!w) model_rdata[idx] = din;
  endtask

  task automatic test_reset;
    logic [29:0] got;
    for (int i = 0; i < 3; i++) begin
      got = {cs_v[i], rd_n_v[i], wr_n_v[i], done_v[i], ready_v[i], oe_v[i], addr_v[i], dout_v[i], rdata_v[i]};
      checks++;
      if (got !== {6'b111010, 24'h000000}) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h expected %h", i, got, {6'b111010, 24'h000000});
      end
    end
  endtask

  task automatic test_read;
    int cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il;
    logic re, oe;
    run_access(0, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il, re, oe);
    checks++;
    if (cs_low !== 4) begin errors++; $display("FAIL read_cs_low: got %0d expected 4", cs_low); end
    checks++;
    if (rd_low !== 2 || wr_low !== 0 || fs !== 2) begin
      errors++; $display("FAIL read_strobe: rd=%0d wr=%0d first=%0d expected 2 0 2", rd_low, wr_low, fs);
    end
    checks++;
    if (da !== 4 || dc !== 1) begin errors++; $display("FAIL read_done: at=%0d cnt=%0d expected 4 1", da, dc); end
    checks++;
    if (rdata_v[0] !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h expected a5", rdata_v[0]); end
    checks++;
    if (ab !== 0 || ob !== 0 || il !== 0 || re !== 1'b1) begin
      errors++; $display("FAIL read_bus: addr_bad=%0d oe_bad=%0d illegal=%0d ready=%b", ab, ob, il, re);
    end
  endtask

  task automatic test_write;
    int cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il;
    logic re, oe;
    run_access(0, 1'b1, 8'hC3, 8'h5A, 8'h3C, 1'b0, cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il, re, oe);
    checks++;
    if (cs_low !== 6 || wr_low !== 4 || rd_low !== 0) begin
      errors++; $display("FAIL write_lengths: cs=%0d wr=%0d rd=%0d expected 6 4 0", cs_low, wr_low, rd_low);
    end
    checks++;
    if (ob !== 0 || db !== 0 || oe !== 1'b0) begin
      errors++; $display("FAIL write_data: oe_bad=%0d dout_bad=%0d oe_after=%b", ob, db, oe);
    end
    checks++;
    if (rdata_v[0] !== model_rdata[0]) begin
      errors++; $display("FAIL write_rdata: got %h expected %h", rdata_v[0], model_rdata[0]);
    end
    checks++;
    if (da !== 6 || dc !== 1 || il !== 0) begin
      errors++; $display("FAIL write_done: at=%0d cnt=%0d illegal=%0d expected 6 1 0", da, dc, il);
    end
  endtask

  task automatic test_back_to_back;
    logic cs_h [1:24];
    logic done_h [1:24];
    logic [7:0] addr_h [1:24];
    int wa, wb, run1, gap, run2, k2, d1, d2;
    wa = exp_wait(0, 8'h40);
    wb = exp_wait(0, 8'h80);
    @(negedge clk);
    wr = 1'b0; addr_in = 8'h40; data_in = 8'h11; req_v = 3'b001;
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      cs_h[k] = cs_v[0]; done_h[k] = done_v[0]; addr_h[k] = addr_v[0];
      if (k == 1) addr_in = 8'h80;
      if (k == wa + 3) data_in = 8'h22;
      if (k == wa + 5) req_v = 3'b000;
    end
    run1 = 0; gap = 0; run2 = 0; k2 = 0; d1 = 0; d2 = 0;
    for (int k = 1; k <= 24; k++) begin
      if (cs_h[k] === 1'b0 && gap == 0) run1++;
      else if (cs_h[k] !== 1'b0 && run2 == 0) gap++;
      else if (cs_h[k] === 1'b0) begin run2++; if (k2 == 0) k2 = k; end
      if (done_h[k] === 1'b1 && d1 == 0) d1 = k;
      else if (done_h[k] === 1'b1) d2 = k;
    end
    if (k2 == 0) k2 = 24;
    checks++;
    if (run1 !== wa + 3 || run2 !== wb + 3) begin
      errors++; $display("FAIL b2b_runs: run1=%0d run2=%0d expected %0d %0d", run1, run2, wa + 3, wb + 3);
    end
    checks++;
    if (cs_h[wa + 4] !== 1'b1 || cs_h[wa + 5] !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: cs at %0d,%0d = %b%b expected 10", wa + 4, wa + 5, cs_h[wa + 4], cs_h[wa + 5]);
    end
    checks++;
    if (addr_h[k2] !== 8'h80 || addr_h[1] !== 8'h40) begin
      errors++; $display("FAIL b2b_addr: first=%h second=%h expected 40 80", addr_h[1], addr_h[k2]);
    end
    checks++;
    if (d1 !== wa + 3 || d2 !== wa + wb + 7) begin
      errors++; $display("FAIL b2b_done: at %0d and %0d expected %0d %0d", d1, d2, wa + 3, wa + wb + 7);
    end
    model_rdata[0] = 8'h22;
    checks++;
    if (rdata_v[0] !== model_rdata[0]) begin
      errors++; $display("FAIL b2b_rdata: got %h expected %h", rdata_v[0], model_rdata[0]);
    end
  endtask

  task automatic test_reset_mid;
    int cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il;
    int done_seen;
    logic re, oe;
    logic [3:0] bus;
    done_seen = 0;
    @(negedge clk);
    wr = 1'b0; addr_in = 8'h80; data_in = 8'h99; req_v = 3'b001;
    @(posedge clk);
    #1 req_v = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) done_seen++;
    end
    checks++;
    if (rd_n_v[0] !== 1'b0 || cs_v[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_strobe: cs=%b rd_n=%b expected 0 0", cs_v[0], rd_n_v[0]);
    end
    #2 reset = 1'b1;
    #1 bus = {cs_v[0], rd_n_v[0], wr_n_v[0], done_v[0]};
    checks++;
    if (bus !== 4'b1110) begin errors++; $display("FAIL rstmid_async: cs,rd_n,wr_n,done=%b expected 1110", bus); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) done_seen++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) model_rdata[i] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0 || ready_v[0] !== 1'b1 || rdata_v[0] !== 8'h00) begin
      errors++; $display("FAIL rstmid_abort: done_seen=%0d ready=%b rdata=%h expected 0 1 00", done_seen, ready_v[0], rdata_v[0]);
    end
    run_access(0, 1'b0, 8'h01, 8'h00, 8'h77, 1'b0, cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il, re, oe);
    checks++;
    if (cs_low !== 4 || rdata_v[0] !== 8'h77) begin
      errors++; $display("FAIL rstmid_reaccept: cs=%0d rdata=%h expected 4 77", cs_low, rdata_v[0]);
    end
  endtask

  task automatic test_wait_extremes;
    int cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il;
    logic re, oe;
    run_access(1, 1'b1, 8'h05, 8'hE1, 8'h00, 1'b0, cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il, re, oe);
    checks++;
    if (wr_low !== 1 || rd_low !== 0 || cs_low !== 3 || da !== 3) begin
      errors++; $display("FAIL wait0_write: wr=%0d rd=%0d cs=%0d done_at=%0d expected 1 0 3 3", wr_low, rd_low, cs_low, da);
    end
    run_access(2, 1'b0, 8'h3F, 8'h00, 8'hB7, 1'b0, cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il, re, oe);
    checks++;
    if (rd_low !== 16 || wr_low !== 0 || cs_low !== 18 || da !== 18) begin
      errors++; $display("FAIL wait15_read: rd=%0d wr=%0d cs=%0d done_at=%0d expected 16 0 18 18", rd_low, wr_low, cs_low, da);
    end
    checks++;
    if (rdata_v[2] !== 8'hB7) begin errors++; $display("FAIL wait15_rdata: got %h expected b7", rdata_v[2]); end
  endtask

  task automatic test_ignore_busy_inputs;
    int cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il;
    logic re, oe;
    run_access(0, 1'b0, 8'h8E, 8'h44, 8'h6D, 1'b1, cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il, re, oe);
    checks++;
    if (cs_low !== 5 || rd_low !== 3 || wr_low !== 0 || da !== 5) begin
      errors++; $display("FAIL ignore_length: cs=%0d rd=%0d wr=%0d done_at=%0d expected 5 3 0 5", cs_low, rd_low, wr_low, da);
    end
    checks++;
    if (ab !== 0 || db !== 0 || rdata_v[0] !== 8'h6D) begin
      errors++; $display("FAIL ignore_addr: addr_bad=%0d dout_bad=%0d rdata=%h expected 0 0 6d", ab, db, rdata_v[0]);
    end
  endtask

  task automatic test_random;
    int cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il, idx, wt;
    logic re, oe, w;
    logic [7:0] a, wd, din;
    bit noise;
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, 2);
      w = 1'($urandom); a = 8'($urandom); wd = 8'($urandom); din = 8'($urandom);
      noise = 1'($urandom);
      wt = exp_wait(idx, a);
      run_access(idx, w, a, wd, din, noise, cs_low, rd_low, wr_low, fs, da, dc, ab, ob, db, il, re, oe);
      checks++;
      if (cs_low !== wt + 3 || da !== wt + 3 || dc !== 1) begin
        errors++; $display("FAIL rand_timing %0d: cs=%0d done_at=%0d cnt=%0d expected %0d", n, cs_low, da, dc, wt + 3);
      end
      checks++;
      if ((w ? wr_low : rd_low) !== wt + 1 || (w ? rd_low : wr_low) !== 0 || fs !== 2) begin
        errors++; $display("FAIL rand_strobe %0d: rd=%0d wr=%0d first=%0d expected %0d on %s", n, rd_low, wr_low, fs, wt + 1, w ? "wr_n" : "rd_n");
      end
      checks++;
      if (ab !== 0 || ob !== 0 || db !== 0 || il !== 0 || re !== 1'b1 || oe !== 1'b0) begin
        errors++; $display("FAIL rand_bus %0d: addr=%0d oe=%0d dout=%0d illegal=%0d ready=%b oe_end=%b", n, ab, ob, db, il, re, oe);
      end
      checks++;
      if (rdata_v[idx] !== model_rdata[idx]) begin
        errors++; $display("FAIL rand_rdata %0d: got %h expected %h", n, rdata_v[idx], model_rdata[idx]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_v = 3'b000; wr = 1'b0; addr_in = 8'h00; wdata = 8'h00; data_in = 8'h00;
    for (int i = 0; i < 3; i++) model_rdata[i] = 8'h00;
    #12;
    test_reset;
    @(negedge clk);
    reset = 1'b0;
    test_read;
    test_write;
    test_back_to_back;
    test_reset_mid;
    test_wait_extremes;
    test_ignore_busy_inputs;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
